// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and timing defaults.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START_BIT = 2'd1,
        S_DATA_BITS = 2'd2,
        S_STOP_BIT  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int CLK_CNT_W            = 10;
    localparam int DATA_BITS            = 8;

    function automatic logic is_last_tick(input logic [CLK_CNT_W-1:0] cnt,
                                          input int                   clks_per_bit);
        return cnt == CLK_CNT_W'(clks_per_bit - 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous byte FIFO with a combinational head; writes while full are ignored.
module uart_tx_fifo_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Full blocks the write even when a pop lands on the same edge.
    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + (ADDR_W+1)'(do_wr) - (ADDR_W+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed from a byte FIFO so the producer can push bursts.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Tx_DV,
    input  logic [7:0]       i_Tx_Byte,
    output logic             o_Tx_Ready,
    output logic             o_Tx_Serial,
    output logic             o_Tx_Active,
    output logic             o_Tx_Done,
    output logic             o_Overflow,
    output logic [ADDR_W:0]  o_Fifo_Count,
    output tx_state_e        o_Dbg_State
);

    // Handshake: a byte is taken on every edge where i_Tx_DV and o_Tx_Ready are both high;
    // i_Tx_DV while o_Tx_Ready is low drops the byte and pulses o_Overflow one cycle later.

    logic [7:0]  fifo_rd_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic [ADDR_W:0] fifo_count;
    logic        pop;

    tx_state_e            state_q, state_d;
    logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 bit_last;

    uart_tx_fifo_sync_fifo #(
        .WIDTH  (8),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .wr_en   (i_Tx_DV),
        .wr_data (i_Tx_Byte),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_last = is_last_tick(clk_cnt_q, CLKS_PER_BIT);

    // Line outputs are registered from the current state, so they trail the state by one cycle.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        serial_d   = 1'b1;
        active_d   = (state_q != S_IDLE);
        done_d     = 1'b0;
        overflow_d = i_Tx_DV && fifo_full;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rd_data;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_START_BIT;
                end
            end
            S_START_BIT: begin
                serial_d = 1'b0;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA_BITS;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
                end
            end
            S_DATA_BITS: begin
                serial_d = tx_data_q[bit_idx_q];
                if (bit_last) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = S_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
                end
            end
            S_STOP_BIT: begin
                serial_d = 1'b1;
                if (bit_last) begin
                    done_d    = 1'b1;
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            tx_data_q  <= '0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_data_q  <= tx_data_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_Tx_Ready   = !fifo_full;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;
    assign o_Overflow   = overflow_q;
    assign o_Fifo_Count = fifo_count;
    assign o_Dbg_State  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a loopback line decoder recovers frames, compared against written bytes.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          dv;
    logic [7:0]    byte_in;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_active;
    logic          tx_done;
    logic          overflow;
    logic [AW:0]   fifo_count;
    tx_state_e     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         done_cyc_q[$];
    int         mon_bad     = 0;
    int         ovf_pulses  = 0;
    int         peak_count  = 0;
    int         ready_low   = 0;
    int         serial_low  = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Tx_DV      (dv),
        .i_Tx_Byte    (byte_in),
        .o_Tx_Ready   (tx_ready),
        .o_Tx_Serial  (tx_serial),
        .o_Tx_Active  (tx_active),
        .o_Tx_Done    (tx_done),
        .o_Overflow   (overflow),
        .o_Fifo_Count (fifo_count),
        .o_Dbg_State  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- loopback receiver / line monitor ----------------
    logic line_s [FRAME];
    int   nsamp    = 0;
    bit   in_frame = 1'b0;

    always @(negedge clk) begin : line_monitor
        logic [7:0] rb;
        bit         ok;
        if (rst === 1'b1) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx_serial === 1'b0) begin
                in_frame  = 1'b1;
                line_s[0] = 1'b0;
                nsamp     = 1;
                start_q.push_back(cyc);
            end
        end else begin
            line_s[nsamp] = tx_serial;
            nsamp++;
            if (nsamp == FRAME) begin
                ok = 1'b1;
                for (int bi = 0; bi < 10; bi++)
                    for (int k = 1; k < CPB; k++)
                        if (line_s[bi*CPB+k] !== line_s[bi*CPB]) ok = 1'b0;
                if (line_s[0] !== 1'b0) ok = 1'b0;
                if (line_s[9*CPB] !== 1'b1) ok = 1'b0;
                for (int bi = 0; bi < 8; bi++) rb[bi] = line_s[(bi+1)*CPB];
                if (!ok) mon_bad++;
                rx_q.push_back(rb);
                in_frame = 1'b0;
            end
        end
        if (tx_done === 1'b1) done_cyc_q.push_back(cyc);
        if (overflow === 1'b1) ovf_pulses++;
        if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
        if (tx_ready !== 1'b1) ready_low++;
        if (tx_serial !== 1'b1) serial_low++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, output int acc_cyc);
        dv      = 1'b1;
        byte_in = b;
        tick();
        acc_cyc = cyc;
        dv      = 1'b0;
    endtask

    task automatic clear_scoreboard();
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
        done_cyc_q.delete();
        mon_bad    = 0;
        ovf_pulses = 0;
        peak_count = 0;
        ready_low  = 0;
        serial_low = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clear_scoreboard();
    endtask

    task automatic wait_rx(input int target, input int budget, output bit timed_out);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        timed_out = (rx_q.size() < target);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b1;
        dv      = 1'b0;
        byte_in = 8'h00;
        repeat (3) tick();
        n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b expected 1", tx_serial); end
        n_checks++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", tx_active); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
        rst = 1'b0;
        tick();
        clear_scoreboard();
    endtask

    task automatic test_idle();
        do_reset();
        repeat (1000) tick();
        n_checks++; if (serial_low != 0) begin n_fail++; $display("FAIL idle_serial: got %0d low cycles expected 0", serial_low); end
        n_checks++; if (done_cyc_q.size() != 0) begin n_fail++; $display("FAIL idle_done: got %0d pulses expected 0", done_cyc_q.size()); end
    endtask

    task automatic test_single(input logic [7:0] b);
        int acc;
        bit to;
        repeat (3) tick();
        clear_scoreboard();
        exp_q.push_back(b);
        write_byte(b, acc);
        n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL single_line_n: got %b expected 1", tx_serial); end
        tick();
        n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL single_line_n1: got %b expected 1", tx_serial); end
        tick();
        n_checks++; if (tx_serial !== 1'b0) begin n_fail++; $display("FAIL single_line_n2: got %b expected 0", tx_serial); end
        n_checks++; if (tx_active !== 1'b1) begin n_fail++; $display("FAIL single_active: got %b expected 1", tx_active); end
        wait_rx(1, FRAME + 40, to);
        repeat (20) tick();
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got %0d frames expected 1", rx_q.size()); end
        n_checks++; if (rx_q.size() != 1 || rx_q[0] !== b) begin n_fail++; $display("FAIL single_byte: got %0h expected %0h", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b); end
        n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL single_frame_shape: got %0d malformed expected 0", mon_bad); end
        n_checks++; if (start_q.size() != 1 || start_q[0] != acc + 2) begin n_fail++; $display("FAIL single_start_cycle: got %0d expected %0d", (start_q.size() > 0) ? start_q[0] : -1, acc + 2); end
        n_checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc + 2 + FRAME - 1) begin n_fail++; $display("FAIL single_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, acc + 2 + FRAME - 1); end
        n_checks++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL single_active_end: got %b expected 0", tx_active); end
    endtask

    task automatic test_burst();
        int acc;
        bit to;
        logic [7:0] b;
        repeat (3) tick();
        clear_scoreboard();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            write_byte(b, acc);
        end
        wait_rx(4, 4 * (FRAME + 1) + 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL burst_timeout: got %0d frames expected 4", rx_q.size()); end
        n_checks++; if (peak_count != 3) begin n_fail++; $display("FAIL burst_peak_count: got %0d expected 3", peak_count); end
        n_checks++; if (ready_low != 0) begin n_fail++; $display("FAIL burst_ready: got %0d not-ready cycles expected 0", ready_low); end
        n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_size: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]); end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            n_checks++; if (start_q[i] - start_q[i-1] != FRAME + 1) begin n_fail++; $display("FAIL burst_gap%0d: got %0d expected %0d", i, start_q[i] - start_q[i-1], FRAME + 1); end
        end
        n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL burst_frame_shape: got %0d malformed expected 0", mon_bad); end
    endtask

    task automatic test_overflow();
        int acc;
        int held;
        int n;
        bit to;
        bit exp_ready;
        logic [7:0] b;
        repeat (3) tick();
        clear_scoreboard();
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        write_byte(b, acc);
        n = 0;
        while (tx_active !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (tx_active !== 1'b1) begin n_fail++; $display("FAIL ovf_active: got %b expected 1", tx_active); end
        repeat ($urandom_range(0, 30)) tick();
        held = 0;
        for (int i = 0; i < 5; i++) begin
            exp_ready = (held < DEPTH);
            n_checks++; if (tx_ready !== exp_ready) begin n_fail++; $display("FAIL ovf_ready%0d: got %b expected %b", i, tx_ready, exp_ready); end
            b = 8'($urandom_range(0, 255));
            write_byte(b, acc);
            if (exp_ready) begin
                exp_q.push_back(b);
                held++;
            end
            n_checks++; if (overflow !== !exp_ready) begin n_fail++; $display("FAIL ovf_pulse%0d: got %b expected %b", i, overflow, !exp_ready); end
            n_checks++; if (int'(fifo_count) != held) begin n_fail++; $display("FAIL ovf_count%0d: got %0d expected %0d", i, fifo_count, held); end
        end
        wait_rx(5, 5 * (FRAME + 1) + 100, to);
        repeat (3 * FRAME) tick();
        n_checks++; if (to) begin n_fail++; $display("FAIL ovf_timeout: got %0d frames expected 5", rx_q.size()); end
        n_checks++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_size: got %0d expected 5", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (ovf_pulses != 1) begin n_fail++; $display("FAIL ovf_pulse_total: got %0d expected 1", ovf_pulses); end
        n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL ovf_frame_shape: got %0d malformed expected 0", mon_bad); end
    endtask

    task automatic test_same_cycle_pop();
        int acc;
        bit to;
        logic [7:0] b;
        repeat (3) tick();
        clear_scoreboard();
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        write_byte(b, acc);
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL pop_count_first: got %0d expected 1", fifo_count); end
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        write_byte(b, acc);
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL pop_count_same_cycle: got %0d expected 1", fifo_count); end
        wait_rx(2, 2 * (FRAME + 1) + 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL pop_timeout: got %0d frames expected 2", rx_q.size()); end
        for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pop_byte%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int acc;
        bit to;
        logic [7:0] b;
        repeat (3) tick();
        clear_scoreboard();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            write_byte(b, acc);
            repeat ($urandom_range(50, 150)) tick();
        end
        wait_rx(8, 8 * (FRAME + 1) + 100, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rand_timeout: got %0d frames expected 8", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (ovf_pulses != 0) begin n_fail++; $display("FAIL rand_overflow: got %0d pulses expected 0", ovf_pulses); end
        n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL rand_frame_shape: got %0d malformed expected 0", mon_bad); end
    endtask

    task automatic test_reset_mid();
        int acc0;
        int acc;
        int target;
        repeat (3) tick();
        clear_scoreboard();
        write_byte(8'($urandom_range(0, 255)), acc0);
        write_byte(8'($urandom_range(0, 255)), acc);
        write_byte(8'($urandom_range(0, 255)), acc);
        n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL mid_queued: got %0d expected 2", fifo_count); end
        // Data bits occupy the line from start+CPB to start+9*CPB-1; the frame starts at acc0+2.
        target = acc0 + 2 + CPB + $urandom_range(2, 7 * CPB);
        while (cyc < target - 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL mid_serial: got %b expected 1", tx_serial); end
        n_checks++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL mid_active: got %b expected 0", tx_active); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", tx_ready); end
        repeat (4 * FRAME) tick();
        n_checks++; if (start_q.size() != 1) begin n_fail++; $display("FAIL mid_no_new_frames: got %0d starts expected 1", start_q.size()); end
        n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_no_rx: got %0d frames expected 0", rx_q.size()); end
        n_checks++; if (done_cyc_q.size() != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cyc_q.size()); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_idle();
        test_single(8'hA5);
        test_single(8'($urandom_range(0, 255)));
        test_burst();
        test_overflow();
        test_same_cycle_pop();
        test_random();
        test_reset_mid();
        test_single(8'($urandom_range(0, 255)));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
